// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and defaults for the register-bank writeback arbiter.
// Holds widths, requester ids, round-robin pointer and write-stage encodings.
package reg_wb_arbiter_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } rr_ptr_t;

  typedef enum logic {
    WS_IDLE  = 1'b0,
    WS_WRITE = 1'b1
  } ws_t;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback request bundle: ALU and load valid/ready handshakes.
// master = requester side (execute/memory), slave = arbiter side.
import reg_wb_arbiter_pkg::*;

interface reg_wb_arbiter_if #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready
  );
endinterface

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: req[1:0] -> one-hot gnt[1:0].
// Pointer names the preferred side and moves to the other side after any grant.
import reg_wb_arbiter_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output rr_ptr_t    ptr
);
  rr_ptr_t ptr_nxt;

  always_comb begin
    gnt = 2'b00;
    gnt[REQ_ALU] = req[REQ_ALU]
                 & (~req[REQ_MEM] | (ptr == PRI_ALU));
    gnt[REQ_MEM] = req[REQ_MEM]
                 & (~req[REQ_ALU] | (ptr == PRI_MEM));
  end

  // Contested or not, the winner yields priority to the other side.
  always_comb begin
    ptr_nxt = ptr;
    unique case (1'b1)
      gnt[REQ_ALU]: ptr_nxt = PRI_MEM;
      gnt[REQ_MEM]: ptr_nxt = PRI_ALU;
      default:      ptr_nxt = ptr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= PRI_ALU;
    else        ptr <= ptr_nxt;
  end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register bank write port between ALU and load writeback.
// Ports: clk/rst_n, req (slave handshakes), wb_* to bank, rd_addr/bank_reg in, fwd_reg out.
import reg_wb_arbiter_pkg::*;

module reg_wb_arbiter #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_wb_arbiter_if.slave   req,
  output logic              wb_r_w,
  output logic [ADDR_W-1:0] wb_write_reg,
  output logic [DATA_W-1:0] wb_reg_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] bank_reg_a,
  input  logic [DATA_W-1:0] bank_reg_b,
  output logic [DATA_W-1:0] fwd_reg_a,
  output logic [DATA_W-1:0] fwd_reg_b
);
  logic [1:0] req_v;
  logic [1:0] gnt;
  rr_ptr_t    rr_ptr;
  ws_t        ws;
  ws_t        ws_nxt;

  // Gating with rst_n keeps ready low throughout reset.
  assign req_v[REQ_ALU] = req.alu_valid & rst_n;
  assign req_v[REQ_MEM] = req.mem_valid & rst_n;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_v),
    .gnt   (gnt),
    .ptr   (rr_ptr)
  );

  assign req.alu_ready = gnt[REQ_ALU];
  assign req.mem_ready = gnt[REQ_MEM];

  always_comb begin
    ws_nxt = WS_IDLE;
    if (|gnt) ws_nxt = WS_WRITE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws           <= WS_IDLE;
      wb_write_reg <= '0;
      wb_reg_data  <= '0;
    end else begin
      ws <= ws_nxt;
      unique case (1'b1)
        gnt[REQ_ALU]: begin
          wb_write_reg <= req.alu_addr;
          wb_reg_data  <= req.alu_data;
        end
        gnt[REQ_MEM]: begin
          wb_write_reg <= req.mem_addr;
          wb_reg_data  <= req.mem_data;
        end
        default: ;
      endcase
    end
  end

  assign wb_r_w = (ws == WS_WRITE);

  // Bypass the write landing this cycle so readers never see stale data.
  assign fwd_reg_a = (wb_r_w && rd_addr_a == wb_write_reg)
                   ? wb_reg_data : bank_reg_a;
  assign fwd_reg_b = (wb_r_w && rd_addr_b == wb_write_reg)
                   ? wb_reg_data : bank_reg_b;

  // rr_ptr is only observed through the grants.
  logic unused_ptr;
  assign unused_ptr = ^rr_ptr;
endmodule
